panda_pipeline_controller: RTL and testbench

//  Central stall/flush/redirect sequencer for the 5-stage Panda pipeline.

---
 rtl/panda_pkg.sv | 20 ++
 rtl/panda_pipeline_controller.sv | 135 +++++++++++++
 tb/tb_panda_pipeline_controller.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/panda_pkg.sv
// Shared types for the Panda pipeline control path: sequencer states, redirect
// causes and the default trap entry point.
package panda_pkg;

   typedef enum logic [2:0] {
      RUN,
      DRAIN,
      TRAP,
      HALT,
      RESUME
   } ctrl_state_e;

   typedef enum logic {
      CAUSE_TRAP,
      CAUSE_HALT
   } ctrl_cause_e;

   localparam logic [31:0] TRAP_VECTOR_DEFAULT = 32'h0000_0100;

endpackage

// File: rtl/panda_pipeline_controller.sv
// Stall/flush/redirect sequencer for the 5-stage Panda pipeline: merges ID hazards
// with memory waits and sequences illegal-instruction traps and debug halt/resume.
module panda_pipeline_controller
   import panda_pkg::*;
#(
   parameter logic [31:0] TrapVector  = TRAP_VECTOR_DEFAULT,
   parameter int unsigned DrainCycles = 3
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        id_valid_i,
   input  logic [31:0] id_pc_i,
   input  logic        id_bubble_i,
   input  logic        id_change_flow_i,
   input  logic        id_illegal_i,
   input  logic        imem_wait_i,
   input  logic        lsu_wait_i,
   input  logic        halt_req_i,
   input  logic        resume_i,
   output logic        stall_if_o,
   output logic        stall_id_o,
   output logic        stall_ex_o,
   output logic        flush_if_o,
   output logic        flush_id_o,
   output logic        redirect_o,
   output logic [31:0] redirect_pc_o,
   output logic [31:0] epc_o,
   output logic        halted_o
);

   localparam int CntW = $clog2(DrainCycles + 1);
   localparam logic [CntW-1:0] CntLoad = CntW'(DrainCycles - 1);

   ctrl_state_e     state_q, state_d;
   ctrl_cause_e     cause_q, cause_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [31:0]     epc_q, epc_d;

   logic stall_if, stall_id, stall_ex, flush_if, flush_id;

   always_comb begin
      state_d  = state_q;
      cause_d  = cause_q;
      cnt_d    = cnt_q;
      epc_d    = epc_q;
      stall_if = 1'b0;
      stall_id = 1'b0;
      stall_ex = 1'b0;
      flush_if = 1'b0;
      flush_id = 1'b0;
      case (state_q)
         RUN: begin
            if (lsu_wait_i) begin
               stall_if = 1'b1;
               stall_id = 1'b1;
               stall_ex = 1'b1;
            end else if (id_bubble_i) begin
               stall_if = 1'b1;
               stall_id = 1'b1;
               flush_id = 1'b1;
            end else if (id_valid_i && (id_illegal_i || halt_req_i)) begin
               // Squash the ID instruction and let older ones retire before redirecting.
               epc_d    = id_pc_i;
               cause_d  = id_illegal_i ? CAUSE_TRAP : CAUSE_HALT;
               cnt_d    = CntLoad;
               stall_if = 1'b1;
               flush_if = 1'b1;
               flush_id = 1'b1;
               state_d  = DRAIN;
            end else if (id_change_flow_i) begin
               flush_if = 1'b1;
            end else if (imem_wait_i) begin
               stall_if = 1'b1;
               flush_if = 1'b1;
            end
         end
         DRAIN: begin
            stall_if = 1'b1;
            flush_if = 1'b1;
            flush_id = 1'b1;
            if (lsu_wait_i) begin
               stall_ex = 1'b1;
            end else if (cnt_q == '0) begin
               state_d = (cause_q == CAUSE_TRAP) ? TRAP : HALT;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         TRAP: begin
            flush_if = 1'b1;
            flush_id = 1'b1;
            state_d  = RUN;
         end
         HALT: begin
            stall_if = 1'b1;
            flush_if = 1'b1;
            flush_id = 1'b1;
            if (resume_i) state_d = RESUME;
         end
         RESUME: begin
            flush_if = 1'b1;
            flush_id = 1'b1;
            state_d  = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= RUN;
         cause_q <= CAUSE_TRAP;
         cnt_q   <= '0;
         epc_q   <= '0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         cnt_q   <= cnt_d;
         epc_q   <= epc_d;
      end
   end

   // Gating with rst_ni keeps every output low while reset is held, even with lsu_wait_i up.
   assign stall_if_o    = rst_ni & stall_if;
   assign stall_id_o    = rst_ni & stall_id;
   assign stall_ex_o    = rst_ni & stall_ex;
   assign flush_if_o    = rst_ni & flush_if;
   assign flush_id_o    = rst_ni & flush_id;
   assign redirect_o    = (state_q == TRAP) || (state_q == RESUME);
   assign redirect_pc_o = (state_q == TRAP)   ? TrapVector :
                          (state_q == RESUME) ? epc_q      : 32'h0;
   assign epc_o         = epc_q;
   assign halted_o      = (state_q == HALT);

endmodule

// File: tb/tb_panda_pipeline_controller.sv
// Self-checking bench: directed scenarios plus random traffic, compared each cycle
// against a cycle-count reference model of the stall/flush/redirect rules.
module tb_panda_pipeline_controller;

   localparam logic [31:0] TV = 32'h0000_0100;
   localparam int          DC = 3;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        id_valid, id_bubble, id_change_flow, id_illegal;
   logic        imem_wait, lsu_wait, halt_req, resume;
   logic [31:0] id_pc;
   logic        stall_if, stall_id, stall_ex, flush_if, flush_id, redirect, halted;
   logic [31:0] redirect_pc, epc;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   string tag = "reset";

   // Reference model: pending redirect, halted flag, and remaining non-wait drain cycles.
   bit          m_redir, m_redir_trap, m_halted, m_cause_halt;
   int          m_drain;
   logic [31:0] m_epc;

   always #5 clk = ~clk;

   panda_pipeline_controller #(.TrapVector(TV), .DrainCycles(DC)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .id_valid_i(id_valid), .id_pc_i(id_pc), .id_bubble_i(id_bubble),
      .id_change_flow_i(id_change_flow), .id_illegal_i(id_illegal),
      .imem_wait_i(imem_wait), .lsu_wait_i(lsu_wait),
      .halt_req_i(halt_req), .resume_i(resume),
      .stall_if_o(stall_if), .stall_id_o(stall_id), .stall_ex_o(stall_ex),
      .flush_if_o(flush_if), .flush_id_o(flush_id),
      .redirect_o(redirect), .redirect_pc_o(redirect_pc),
      .epc_o(epc), .halted_o(halted)
   );

   task automatic model_reset();
      m_redir = 0; m_redir_trap = 0; m_halted = 0; m_cause_halt = 0;
      m_drain = 0; m_epc = '0;
   endtask

   task automatic clear_inputs();
      id_valid = 0; id_pc = '0; id_bubble = 0; id_change_flow = 0; id_illegal = 0;
      imem_wait = 0; lsu_wait = 0; halt_req = 0; resume = 0;
   endtask

   function automatic logic [70:0] model_out();
      logic si, sd, se, fi, fd, rd, h;
      logic [31:0] rp;
      {si, sd, se, fi, fd, rd, h} = '0;
      rp = '0;
      if (!rst_ni) begin
         // everything low
      end else if (m_redir) begin
         rd = 1; fi = 1; fd = 1;
         rp = m_redir_trap ? TV : m_epc;
      end else if (m_halted) begin
         h = 1; si = 1; fi = 1; fd = 1;
      end else if (m_drain > 0) begin
         si = 1; fi = 1; fd = 1; se = lsu_wait;
      end else if (lsu_wait) begin
         si = 1; sd = 1; se = 1;
      end else if (id_bubble) begin
         si = 1; sd = 1; fd = 1;
      end else if (id_valid && (id_illegal || halt_req)) begin
         si = 1; fi = 1; fd = 1;
      end else if (id_change_flow) begin
         fi = 1;
      end else if (imem_wait) begin
         si = 1; fi = 1;
      end
      return {si, sd, se, fi, fd, rd, h, rp, m_epc};
   endfunction

   task automatic settle();
      logic [70:0] e, o;
      #1;
      e = model_out();
      o = {stall_if, stall_id, stall_ex, flush_if, flush_id, redirect, halted, redirect_pc, epc};
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, o, e);
      end
   endtask

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", name, cyc, obs, exp);
      end
   endtask

   task automatic adv();
      if (m_redir) begin
         m_redir = 0;
      end else if (m_halted) begin
         if (resume) begin m_halted = 0; m_redir = 1; m_redir_trap = 0; end
      end else if (m_drain > 0) begin
         if (!lsu_wait) begin
            if (m_drain == 1) begin
               m_drain = 0;
               if (m_cause_halt) m_halted = 1;
               else begin m_redir = 1; m_redir_trap = 1; end
            end else m_drain--;
         end
      end else if (!lsu_wait && !id_bubble && id_valid && (id_illegal || halt_req)) begin
         m_epc = id_pc; m_cause_halt = !id_illegal; m_drain = DC;
      end
      @(negedge clk);
      cyc++;
   endtask

   initial begin
      logic [4:0] lsu_pat;
      clear_inputs();
      rst_ni = 0;
      model_reset();
      @(negedge clk); @(negedge clk);
      settle();
      chk("reset_epc", epc, 32'h0);
      rst_ni = 1;

      // 1: lsu_wait beats bubble, then bubble flushes ID-EX
      tag = "t1";
      lsu_wait = 1; id_bubble = 1; id_valid = 1; id_pc = 32'h20;
      settle();
      chk("t1_stall_ex", {31'b0, stall_ex}, 32'd1);
      chk("t1_flush_id_off", {31'b0, flush_id}, 32'd0);
      adv();
      lsu_wait = 0;
      settle();
      chk("t1_flush_id_on", {31'b0, flush_id}, 32'd1);
      adv();
      clear_inputs();

      // 2: illegal at 0x40 -> 3 drain cycles then redirect to trap vector
      tag = "t2";
      id_valid = 1; id_pc = 32'h40; id_illegal = 1;
      settle(); adv();
      clear_inputs();
      for (int i = 0; i < DC; i++) begin
         settle();
         chk("t2_drain_noredir", {31'b0, redirect}, 32'd0);
         adv();
      end
      settle();
      chk("t2_redirect", {31'b0, redirect}, 32'd1);
      chk("t2_redirect_pc", redirect_pc, 32'h100);
      chk("t2_epc", epc, 32'h40);
      adv();
      settle();
      chk("t2_run_again", {31'b0, redirect}, 32'd0);
      adv();

      // 3: lsu_wait during drain stretches it by one cycle per wait cycle
      tag = "t3";
      id_valid = 1; id_pc = 32'h40; id_illegal = 1;
      settle(); adv();
      clear_inputs();
      lsu_pat = 5'b00110;
      for (int i = 0; i < 5; i++) begin
         lsu_wait = lsu_pat[i];
         settle();
         chk("t3_stall_ex", {31'b0, stall_ex}, {31'b0, lsu_pat[i]});
         chk("t3_noredir", {31'b0, redirect}, 32'd0);
         adv();
      end
      lsu_wait = 0;
      settle();
      chk("t3_redirect_pc", redirect_pc, 32'h100);
      adv();

      // 4: halt waits for a valid instruction, then resume refetches it
      tag = "t4";
      halt_req = 1;
      for (int i = 0; i < 2; i++) begin
         settle();
         chk("t4_pending", {31'b0, stall_if}, 32'd0);
         adv();
      end
      id_valid = 1; id_pc = 32'h80;
      settle(); adv();
      clear_inputs();
      for (int i = 0; i < DC; i++) begin settle(); adv(); end
      settle();
      chk("t4_halted", {31'b0, halted}, 32'd1);
      adv();
      resume = 1;
      settle(); adv();
      resume = 0;
      settle();
      chk("t4_resume_pc", redirect_pc, 32'h80);
      chk("t4_unhalted", {31'b0, halted}, 32'd0);
      adv();

      // 5: illegal beats halt and change_flow
      tag = "t5";
      id_valid = 1; id_pc = 32'h200; id_illegal = 1; halt_req = 1; id_change_flow = 1;
      settle();
      chk("t5_flush_if", {31'b0, flush_if}, 32'd1);
      adv();
      clear_inputs();
      for (int i = 0; i < DC; i++) begin settle(); adv(); end
      settle();
      chk("t5_trap_pc", redirect_pc, 32'h100);
      chk("t5_halted", {31'b0, halted}, 32'd0);
      adv();

      // 6: asynchronous reset mid-drain
      tag = "t6";
      id_valid = 1; id_pc = 32'h300; id_illegal = 1;
      settle(); adv();
      clear_inputs();
      settle(); adv();
      lsu_wait = 1;
      #2;
      rst_ni = 0;
      model_reset();
      settle();
      chk("t6_stall_if_rst", {31'b0, stall_if}, 32'd0);
      chk("t6_epc_rst", epc, 32'h0);
      @(negedge clk);
      rst_ni = 1; lsu_wait = 0;
      settle();
      chk("t6_run_after", {31'b0, flush_id}, 32'd0);
      adv();

      // random traffic against the model
      tag = "rand";
      for (int n = 0; n < 3000; n++) begin
         id_valid       = ($urandom_range(0, 3) != 0);
         id_pc          = {$urandom_range(0, 16'hffff), 2'b00} & 32'h0003_fffc;
         id_bubble      = ($urandom_range(0, 7) == 0);
         id_change_flow = ($urandom_range(0, 7) == 0);
         id_illegal     = ($urandom_range(0, 15) == 0);
         imem_wait      = ($urandom_range(0, 7) == 0);
         lsu_wait       = ($urandom_range(0, 5) == 0);
         resume         = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 19) == 0) halt_req = ~halt_req;
         settle();
         adv();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
